poly1305_seq_mac: RTL and testbench

//  Parametrised digit-serial Poly1305 MAC core with a valid/ready block interface and per-block byte length.
//  It processes one 16-byte block per transaction: h = ((h + pad(m,len)) * r) mod (2^130-5).
//  On the last block it emits tag = (h mod p + s) mod 2^128.
//  It supersedes the fixed full/partial-block poly1305 core in the AEAD datapath.

---
 rtl/poly1305_seq_mac.sv | 138 +++++++++++++
 tb/tb_poly1305_seq_mac.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/poly1305_seq_mac.sv
// Digit-serial Poly1305 MAC: one 16-byte block per transaction, tag on the last block.
// Define POLY1305_CLAMP_EN to clamp r internally when it is latched.
module poly1305_seq_mac #(
  parameter int DIGIT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         first,
  input  logic         last,
  input  logic [4:0]   len,
  input  logic [127:0] r,
  input  logic [127:0] s,
  input  logic [127:0] m,
  output logic [127:0] tag,
  output logic         tag_valid
);
  localparam int NUM_DIG = 128 / DIGIT_W;
  localparam int PW      = 131 + DIGIT_W;
  localparam logic [130:0] P = (131'd1 << 130) - 131'd5;

  typedef enum logic [2:0] {IDLE, ADD, MUL, RED1, RED2, FIN} state_t;
  state_t r_state, w_next;

  logic [130:0] r_h, r_a;
  logic [127:0] r_r, r_s, r_tag;
  logic [128:0] r_pad;
  logic [258:0] r_acc;
  logic [7:0]   r_dig;
  logic         r_first, r_last, r_tag_valid;

  logic [4:0]          w_len;
  logic [128:0]        w_pad;
  logic [127:0]        w_r_in;
  logic [DIGIT_W-1:0]  w_dig;
  logic [PW-1:0]       w_prod;
  logic [258:0]        w_mac;
  logic [131:0]        w_fold;
  logic [130:0]        w_h1, w_h2;
  logic [127:0]        w_tag;

  assign w_len = (len == 5'd0 || len > 5'd16) ? 5'd16 : len;

  // Keep the low len bytes and set the pad bit just above them.
  always_comb begin
    w_pad = '0;
    for (int i = 0; i < 16; i++)
      if (5'(i) < w_len) w_pad[8*i +: 8] = m[8*i +: 8];
    w_pad[{w_len, 3'b000}] = 1'b1;
  end

`ifdef POLY1305_CLAMP_EN
  assign w_r_in = r & 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
`else
  assign w_r_in = r;
`endif

  // Horner step, most significant digit of r first.
  assign w_dig  = r_r[int'(r_dig)*DIGIT_W +: DIGIT_W];
  assign w_prod = {{DIGIT_W{1'b0}}, r_a} * {131'd0, w_dig};
  assign w_mac  = (r_acc << DIGIT_W) + 259'(w_prod);

  // 2^130 == 5 mod p, so the upper part folds back in times 5.
  assign w_fold = {2'b00, r_acc[129:0]} + {1'b0, r_acc[258:130], 2'b00}
                + {3'b000, r_acc[258:130]};

  assign w_h1  = (r_h  >= P) ? r_h  - P : r_h;
  assign w_h2  = (w_h1 >= P) ? w_h1 - P : w_h1;
  assign w_tag = w_h2[127:0] + r_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = ADD;
      ADD:     w_next = MUL;
      MUL:     if (r_dig == 8'd0) w_next = RED1;
      RED1:    w_next = RED2;
      RED2:    w_next = r_last ? FIN : IDLE;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h         <= '0;
      r_a         <= '0;
      r_r         <= '0;
      r_s         <= '0;
      r_tag       <= '0;
      r_pad       <= '0;
      r_acc       <= '0;
      r_dig       <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_tag_valid <= 1'b0;
    end else begin
      r_tag_valid <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          r_pad   <= w_pad;
          r_first <= first;
          r_last  <= last;
          if (first) begin
            r_r <= w_r_in;
            r_s <= s;
          end
        end
        ADD: begin
          r_a   <= (r_first ? 131'd0 : r_h) + {2'b00, r_pad};
          r_acc <= '0;
          r_dig <= 8'(NUM_DIG - 1);
        end
        MUL: begin
          r_acc <= w_mac;
          r_dig <= r_dig - 8'd1;
        end
        RED1: r_acc <= 259'(w_fold);
        RED2: r_h   <= w_fold[130:0];
        FIN: begin
          r_tag       <= w_tag;
          r_tag_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign tag       = r_tag;
  assign tag_valid = r_tag_valid;
endmodule

// File: tb/tb_poly1305_seq_mac.sv
// Directed bench for poly1305_seq_mac at DIGIT_W = 32, 8 and 128.
module tb_poly1305_seq_mac;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   in_valid;
  logic         first, last;
  logic [4:0]   len;
  logic [127:0] r, s, m;
  logic         in_ready  [3];
  logic         tag_valid [3];
  logic [127:0] tag       [3];

  int errors = 0;
  int checks = 0;

  localparam int ND [3] = '{4, 16, 1};
  localparam logic [127:0] RFC_R   = 128'h0806d540_0e52447c_036d5554_08bed685;
  localparam logic [127:0] RFC_RU  = 128'ha806d542_fe52447f_336d5557_78bed685;
  localparam logic [127:0] RFC_S   = 128'h1bf54941_aff6bf4a_fdb20dfb_8a800301;
  localparam logic [127:0] RFC_TAG = 128'ha927010c_af8b2bc2_c6365130_c11d06a8;
  localparam logic [127:0] M1      = 128'h6f462063_69687061_72676f74_70797243;
  localparam logic [127:0] M2      = 128'h6f724720_68637261_65736552_206d7572;
  localparam logic [127:0] M3      = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_aaaa7075;

  poly1305_seq_mac #(.DIGIT_W(32)) u_dw32 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .first(first), .last(last), .len(len), .r(r), .s(s), .m(m),
    .tag(tag[0]), .tag_valid(tag_valid[0]));
  poly1305_seq_mac #(.DIGIT_W(8)) u_dw8 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .first(first), .last(last), .len(len), .r(r), .s(s), .m(m),
    .tag(tag[1]), .tag_valid(tag_valid[1]));
  poly1305_seq_mac #(.DIGIT_W(128)) u_dw128 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .first(first), .last(last), .len(len), .r(r), .s(s), .m(m),
    .tag(tag[2]), .tag_valid(tag_valid[2]));

  // Present one block to instance k; lat counts edges until in_ready returns.
  task automatic send(input int k, input logic f, input logic l, input logic [4:0] ln,
                      input logic [127:0] mm, input logic [127:0] rr, input logic [127:0] ss,
                      output int lat, output int early);
    int w = 0;
    while (in_ready[k] !== 1'b1 && w < 300) begin @(posedge clk); #1; w++; end
    @(negedge clk);
    first = f; last = l; len = ln; m = mm; r = rr; s = ss; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0; first = 1'b1; last = 1'b1; len = 5'd3; m = '1; r = '1; s = '1;
    lat = 0; early = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (tag_valid[k] === 1'b1 && in_ready[k] !== 1'b1) early++;
    end while (in_ready[k] !== 1'b1 && lat < 300);
  endtask

  task automatic run_rfc(input int k, input logic [127:0] rr, input string nm);
    int lat, early;
    send(k, 1'b1, 1'b0, 5'd16, M1, rr, RFC_S, lat, early);
    checks++; if (lat !== ND[k] + 3) begin errors++; $display("FAIL %s_lat1 got %0d want %0d", nm, lat, ND[k] + 3); end
    send(k, 1'b0, 1'b0, 5'd16, M2, ~rr, ~RFC_S, lat, early);
    checks++; if (lat !== ND[k] + 3) begin errors++; $display("FAIL %s_lat2 got %0d want %0d", nm, lat, ND[k] + 3); end
    send(k, 1'b0, 1'b1, 5'd2, M3, ~rr, ~RFC_S, lat, early);
    checks++; if (lat !== ND[k] + 4) begin errors++; $display("FAIL %s_lat3 got %0d want %0d", nm, lat, ND[k] + 4); end
    checks++; if (early !== 0) begin errors++; $display("FAIL %s_early got %0d want 0", nm, early); end
    checks++; if (tag_valid[k] !== 1'b1) begin errors++; $display("FAIL %s_tvalid got %b want 1", nm, tag_valid[k]); end
    checks++; if (tag[k] !== RFC_TAG) begin errors++; $display("FAIL %s_tag got %h want %h", nm, tag[k], RFC_TAG); end
    @(posedge clk); #1;
    checks++; if (tag_valid[k] !== 1'b0) begin errors++; $display("FAIL %s_pulse got %b want 0", nm, tag_valid[k]); end
    checks++; if (tag[k] !== RFC_TAG) begin errors++; $display("FAIL %s_hold got %h want %h", nm, tag[k], RFC_TAG); end
  endtask

  task automatic test_reset;
    int lat, early;
    reset = 1'b0; in_valid = '0; first = 1'b0; last = 1'b0; len = '0; r = '0; s = '0; m = '0;
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL rst_ready[%0d] got %b want 1", k, in_ready[k]); end
      checks++; if (tag_valid[k] !== 1'b0) begin errors++; $display("FAIL rst_tvalid[%0d] got %b want 0", k, tag_valid[k]); end
      checks++; if (tag[k] !== 128'd0) begin errors++; $display("FAIL rst_tag[%0d] got %h want 0", k, tag[k]); end
    end
    @(negedge clk); reset = 1'b1;
    // Non-first block straight after reset: r and s stay 0, so the tag is 0.
    send(0, 1'b0, 1'b1, 5'd16, M1, RFC_R, RFC_S, lat, early);
    checks++; if (tag_valid[0] !== 1'b1 || tag[0] !== 128'd0)
      begin errors++; $display("FAIL nofirst_tag got %b/%h want 1/0", tag_valid[0], tag[0]); end
  endtask

  typedef struct packed { logic [4:0] ln; logic [127:0] mm; logic [127:0] ex; } vec_t;

  task automatic test_pad_len;
    int lat, early;
    vec_t tbl [8] = '{
      '{5'd1,  128'd0,       128'h100},
      '{5'd16, 128'd0,       128'd0},
      '{5'd16, {128{1'b1}},  {128{1'b1}}},
      '{5'd15, {128{1'b1}},  128'h01ff_ffff_ffff_ffff_ffff_ffff_ffff_ffff},
      '{5'd1,  128'habcd,    128'h1cd},
      '{5'd0,  128'h1234,    128'h1234},
      '{5'd31, 128'h55,      128'h55},
      '{5'd17, 128'hff00,    128'hff00}};
    for (int i = 0; i < 8; i++) begin
      send(0, 1'b1, 1'b1, tbl[i].ln, tbl[i].mm, 128'd1, 128'd0, lat, early);
      checks++; if (lat !== ND[0] + 4) begin errors++; $display("FAIL pad_lat[%0d] got %0d want %0d", i, lat, ND[0] + 4); end
      checks++; if (tag_valid[0] !== 1'b1 || tag[0] !== tbl[i].ex)
        begin errors++; $display("FAIL pad_tag[%0d] got %b/%h want 1/%h", i, tag_valid[0], tag[0], tbl[i].ex); end
    end
  endtask

  // h = 2^130-2 reaches FIN, needs one subtract of p; s = 2^128-1 wraps the sum.
  task automatic test_final_sub;
    int lat, early;
    send(0, 1'b1, 1'b0, 5'd16, {128{1'b1}}, 128'd1, {128{1'b1}}, lat, early);
    send(0, 1'b0, 1'b1, 5'd16, {128{1'b1}}, 128'd0, 128'd0, lat, early);
    checks++; if (tag_valid[0] !== 1'b1 || tag[0] !== 128'd2)
      begin errors++; $display("FAIL finsub_tag got %b/%h want 1/2", tag_valid[0], tag[0]); end
  endtask

  task automatic test_zero_r;
    int lat, early;
    send(0, 1'b1, 1'b0, 5'd16, M1, 128'd0, 128'hdeadbeef, lat, early);
    checks++; if (lat !== ND[0] + 3) begin errors++; $display("FAIL zr_lat1 got %0d want %0d", lat, ND[0] + 3); end
    send(0, 1'b0, 1'b0, 5'd7, M2, 128'd5, 128'd7, lat, early);
    checks++; if (lat !== ND[0] + 3) begin errors++; $display("FAIL zr_lat2 got %0d want %0d", lat, ND[0] + 3); end
    send(0, 1'b0, 1'b1, 5'd16, M3, 128'd5, 128'd7, lat, early);
    checks++; if (lat !== ND[0] + 4) begin errors++; $display("FAIL zr_lat3 got %0d want %0d", lat, ND[0] + 4); end
    checks++; if (tag[0] !== 128'hdeadbeef) begin errors++; $display("FAIL zr_tag got %h want deadbeef", tag[0]); end
  endtask

  task automatic test_abort;
    int lat, early;
    int seen = 0;
    send(0, 1'b1, 1'b0, 5'd16, M1, RFC_R, RFC_S, lat, early);
    @(negedge clk);
    first = 1'b0; last = 1'b1; len = 5'd16; m = M2; in_valid[0] = 1'b1;
    @(posedge clk); #1; in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", in_ready[0]); end
    checks++; if (tag[0] !== 128'd0) begin errors++; $display("FAIL abort_tag got %h want 0", tag[0]); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (tag_valid[0] !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_tvalid got %0d pulses want 0", seen); end
    run_rfc(0, RFC_R, "rerun");
  endtask

  initial begin
    test_reset();
    run_rfc(0, RFC_R, "rfc32");
    run_rfc(0, RFC_R, "b2b");
    test_pad_len();
    test_final_sub();
    test_zero_r();
    test_abort();
    run_rfc(1, RFC_R, "rfc8");
    run_rfc(2, RFC_R, "rfc128");
`ifdef POLY1305_CLAMP_EN
    run_rfc(0, RFC_RU, "clamp");
`else
    checks++; if (RFC_RU == RFC_R) begin errors++; $display("FAIL clamp_vec got %h want not %h", RFC_RU, RFC_R); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
